// File: rtl/compress_pipe.sv
// Purpose: multi-lane requantiser: shift/round signed sums, clamp to OUT_WIDTH, count saturations.
// Latency: 2 cycles from accepting edge to out_valid (S1 shift/round, S2 clamp); 1 beat/cycle.
// Backpressure: valid/ready; in_ready drops only when S1 and S2 are both full and out_ready=0.
module compress_pipe #(
  parameter int SUM_WIDTH   = 20,
  parameter int OUT_WIDTH   = 8,
  parameter int LANES       = 4,
  parameter int SHIFT_WIDTH = 5,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [SHIFT_WIDTH-1:0]     cfg_shift,
  input  logic                       cfg_round,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*SUM_WIDTH-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*OUT_WIDTH-1:0] out_data,
  output logic [LANES-1:0]           out_sat,
  input  logic                       sat_clr,
  output logic [CNT_WIDTH-1:0]       sat_count
);

  // One extra bit so the rounding add can never wrap.
  localparam int RW = SUM_WIDTH + 1;
  localparam int PW = $clog2(LANES + 1);
  localparam logic [31:0] SH_MAX = 32'(SUM_WIDTH - 1);
  localparam logic signed [RW-1:0] OUT_MAX = RW'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [RW-1:0] OUT_MIN = ~OUT_MAX;

  logic                       s1_valid_q;
  logic [RW-1:0]              s1_r_q [LANES];
  logic [RW-1:0]              s1_r_d [LANES];
  logic                       s2_valid_q;
  logic [LANES*OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic [LANES-1:0]           out_sat_q, out_sat_d;
  logic [CNT_WIDTH-1:0]       sat_count_q, sat_count_d;

  logic        s2_load, s1_adv, accept, xfer;
  logic [31:0] sh;
  logic [RW-1:0] ext;
  logic        gt, lt;
  logic [PW-1:0] pop;
  logic [CNT_WIDTH:0] sum;

  assign s2_load   = !s2_valid_q || out_ready;
  assign s1_adv    = s1_valid_q && s2_load;
  assign in_ready  = !s1_valid_q || s2_load;
  assign accept    = in_valid && in_ready;
  assign xfer      = s2_valid_q && out_ready;
  assign out_valid = s2_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign sat_count = sat_count_q;

  // S1 next value: clamp the shift, optionally add half an LSB, then arithmetic shift.
  always_comb begin
    sh  = (32'(cfg_shift) > SH_MAX) ? SH_MAX : 32'(cfg_shift);
    ext = '0;
    for (int l = 0; l < LANES; l++) begin
      ext = {in_data[l*SUM_WIDTH + SUM_WIDTH - 1], in_data[l*SUM_WIDTH +: SUM_WIDTH]};
      if (cfg_round && (sh != 32'd0)) begin
        ext = ext + (RW'(1) << (sh - 32'd1));
      end
      s1_r_d[l] = $signed(ext) >>> sh;
    end
  end

  // S1 register: loads whenever there is room, so config is captured with its own beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      for (int l = 0; l < LANES; l++) s1_r_q[l] <= '0;
    end else begin
      if (in_ready) s1_valid_q <= in_valid;
      if (accept) begin
        for (int l = 0; l < LANES; l++) s1_r_q[l] <= s1_r_d[l];
      end
    end
  end

  // S2 next value: clamp each lane with a single {gt, lt} select.
  always_comb begin
    out_data_d = '0;
    out_sat_d  = '0;
    gt = 1'b0;
    lt = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      gt = $signed(s1_r_q[l]) > OUT_MAX;
      lt = $signed(s1_r_q[l]) < OUT_MIN;
      case ({gt, lt})
        2'b10:   out_data_d[l*OUT_WIDTH +: OUT_WIDTH] = OUT_MAX[OUT_WIDTH-1:0];
        2'b01:   out_data_d[l*OUT_WIDTH +: OUT_WIDTH] = OUT_MIN[OUT_WIDTH-1:0];
        default: out_data_d[l*OUT_WIDTH +: OUT_WIDTH] = s1_r_q[l][OUT_WIDTH-1:0];
      endcase
      out_sat_d[l] = gt || lt;
    end
  end

  // S2 register: data only changes when a new beat advances, so it holds while stalled or idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      out_data_q <= '0;
      out_sat_q  <= '0;
    end else begin
      if (s2_load) s2_valid_q <= s1_valid_q;
      if (s1_adv) begin
        out_data_q <= out_data_d;
        out_sat_q  <= out_sat_d;
      end
    end
  end

  // Saturation counter next value: add popcount on transfer, stick at all-ones, clear wins.
  always_comb begin
    pop = '0;
    for (int l = 0; l < LANES; l++) pop = pop + PW'(out_sat_q[l]);
    sum = {1'b0, sat_count_q} + (CNT_WIDTH + 1)'(pop);
    sat_count_d = sat_count_q;
    if (sat_clr) begin
      sat_count_d = '0;
    end else if (xfer) begin
      sat_count_d = sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
    end
  end

  // Saturation counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sat_count_q <= '0;
    else     sat_count_q <= sat_count_d;
  end

endmodule

// File: doc/compress_pipe.md
Name: compress_pipe

Overview:
Parametrised, pipelined requantiser that turns LANES signed accumulator sums into saturated OUT_WIDTH-bit results. It sits between the accumulator array and the activation/write-back buffer. Improvements over the fixed 8-bit compressor:
- runtime shift amount
- optional round-half-up
- multi-lane valid/ready streaming with backpressure
- per-lane saturation flags and a saturation event counter

Parameters:
SUM_WIDTH, 20, width of each signed input accumulator lane
OUT_WIDTH, 8, width of each signed output lane (OUT_WIDTH < SUM_WIDTH)
LANES, 4, number of parallel lanes per beat
SHIFT_WIDTH, 5, width of cfg_shift
CNT_WIDTH, 16, width of sat_count

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
cfg_shift  in  SHIFT_WIDTH  arithmetic right-shift amount; sampled with each accepted beat
cfg_round  in  1  1 = round-half-up, 0 = truncate (floor); sampled with each accepted beat
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
in_data  in  LANES*SUM_WIDTH  lane i at bits [i*SUM_WIDTH +: SUM_WIDTH], signed
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_data  out  LANES*OUT_WIDTH  lane i at bits [i*OUT_WIDTH +: OUT_WIDTH], signed
out_sat  out  LANES  lane i was clamped in this output beat
sat_clr  in  1  synchronous clear of sat_count
sat_count  out  CNT_WIDTH  running count of saturated lanes

Behaviour:
- Reset (async, rst=1):
  - s1_valid=0, s2_valid=0, out_valid=0
  - out_data=0, out_sat=0, sat_count=0
  - In-flight beats are discarded.
  - in_ready=1 in the first cycle after rst deasserts.
- Pipeline: two register stages, S1 then S2. out_* are driven directly from S2.
  - Latency: 2 cycles from the accepting edge to out_valid when unstalled.
  - Throughput: 1 beat/cycle.
- Handshake:
  - s2_load = !s2_valid | out_ready
  - s1_adv = s1_valid & s2_load
  - in_ready = !s1_valid | s2_load
  - in_ready depends combinationally on out_ready; this path is permitted.
  - An input beat is accepted on in_valid & in_ready. An output beat is transferred on out_valid & out_ready.
  - While out_valid=1 and out_ready=0: out_data and out_sat hold stable; S1 holds; in_ready=0 once S1 is also full.
  - No beats are dropped or duplicated.
- S1 (shift and round), per lane:
  - Effective shift: sh = min(cfg_shift, SUM_WIDTH-1).
  - Extend x to SUM_WIDTH+1 bits.
  - If cfg_round=1 and sh>0, add 1<<(sh-1).
  - Arithmetic right shift by sh; result r is SUM_WIDTH+1 bits.
  - The extra bit guarantees the rounding add never wraps.
  - cfg_shift and cfg_round are captured per beat, so changes mid-stream affect only newly accepted beats.
- S2 (clamp), per lane, with MAX = 2^(OUT_WIDTH-1)-1 and MIN = -2^(OUT_WIDTH-1):
  - r > MAX: out = MAX, sat = 1
  - r < MIN: out = MIN, sat = 1
  - otherwise: out = r[OUT_WIDTH-1:0], sat = 0
  - Single-mux select on {gt, lt}; gt and lt are mutually exclusive.
- Legacy equivalence: OUT_WIDTH=8, cfg_shift=8, cfg_round=0 gives bit-identical results to the legacy single-lane compressor (floor of sum/256, clamped to [-128, 127]).
- sat_count:
  - On each output transfer, add popcount(out_sat).
  - The count saturates at 2^CNT_WIDTH-1 and does not wrap.
  - If sat_clr=1, the next value is 0. Clear wins over a simultaneous increment.
  - Not affected by stalls: counting happens only on transfer edges.
- in_data with in_valid=0 is ignored. Outputs are don't-care-free: out_data and out_sat keep their last values when out_valid=0.

Test Plan:
- Legacy equivalence: LANES=4, shift=8, round=0, in lanes {0x00380 (896), 0x7FFFF, 0x80000, 0xFFF01 (-255)} -> out {3, 127, -128, -1}, out_sat=4'b0110; out_valid exactly 2 cycles after acceptance.
- Rounding: shift=4, round=1, lanes {24, 23, -24, -25} -> {2, 1, -1, -2}; same beat with round=0 -> {1, 1, -2, -2}. Also shift=0, round=1, lane 100 -> 100 with no rounding add; cfg_shift=31 treated as 19.
- Backpressure: stream 6 consecutive beats while out_ready is held 0 for cycles 3-7 -> in_ready falls once S1 and S2 are full; out_data stays stable while stalled; all 6 beats emerge in order, none lost or duplicated.
- Config change mid-stream: beat A with shift=8, then beat B with shift=4 on the next cycle, both lanes = 0x00100 -> A out 1, B out 16.
- Counter: 3 beats each with 2 saturated lanes -> sat_count=6. sat_clr asserted in the same cycle as a transfer -> sat_count=0. Force the count to max (CNT_WIDTH=4, 15) plus further saturations -> stays 15.
- Reset mid-operation: assert rst while S1 and S2 are both valid -> out_valid=0, sat_count=0 immediately (asynchronous); after release, in_ready=1 and no stale beat appears.
